// File: rtl/data_types.sv
// rtl/data_types.sv - shared types for the reservation station and its neighbours
package data_types;

    typedef logic [31:0] word32_t;
    typedef logic [3:0]  rs_tag_t;

    localparam rs_tag_t NO_VAL = 4'd0;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SLT
    } alu_op_t;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    typedef struct packed {
        logic    busy;
        alu_op_t op;
        word32_t val1;
        rs_tag_t tag1;
        word32_t val2;
        rs_tag_t tag2;
    } rs_entry_t;

    typedef enum logic {
        ISS_SELECT,
        ISS_HOLD
    } iss_state_e;

endpackage

// File: rtl/reservation_station_select.sv
// rtl/reservation_station_select.sv - oldest-ready picker over an age matrix
module rs_select #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]        ready_i,
    // age_i[i][j] set means entry j is older than entry i
    input  logic [N-1:0][N-1:0] age_i,
    output logic [N-1:0]        grant_o,
    output logic                valid_o
);

    for (genvar i = 0; i < N; i++) begin : g_grant
        assign grant_o[i] = ready_i[i] & ~|(ready_i & age_i[i]);
    end

    assign valid_o = |ready_i;

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - operand-capturing reservation station with oldest-first issue
module reservation_station
    import data_types::*;
#(
    parameter int unsigned RS_DEPTH = 4,
    parameter int unsigned TAG_BASE = 1
) (
    input  logic    clk_i,
    input  logic    reset_ni,
    input  cdb_t    cdb_i,
    input  logic    disp_valid_i,
    output logic    disp_ready_o,
    input  alu_op_t disp_op_i,
    input  word32_t disp_val1_i,
    input  word32_t disp_val2_i,
    input  rs_tag_t disp_tag1_i,
    input  rs_tag_t disp_tag2_i,
    output rs_tag_t disp_tag_o,
    output logic    iss_valid_o,
    input  logic    iss_ready_i,
    output alu_op_t iss_op_o,
    output word32_t iss_src1_o,
    output word32_t iss_src2_o,
    output rs_tag_t iss_tag_o
);

    localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

    rs_entry_t                          entry_q [RS_DEPTH];
    rs_entry_t                          entry_d [RS_DEPTH];
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age_q;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0]  age_d;
    iss_state_e                         state_q;
    logic [IDX_W-1:0]                   lock_q;
    logic                               iss_valid_q;

    logic [RS_DEPTH-1:0] busy;
    logic [RS_DEPTH-1:0] ready_vec;
    logic [RS_DEPTH-1:0] grant;
    logic                grant_valid;
    logic                disp_fire;
    logic                iss_fire;
    logic                fwd1;
    logic                fwd2;
    logic [IDX_W-1:0]    free_idx;
    logic [IDX_W-1:0]    grant_idx;

    // The locked entry is masked while held so a handshake can relock the next one
    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            busy[i]      = entry_q[i].busy;
            ready_vec[i] = entry_q[i].busy && (entry_q[i].tag1 == NO_VAL)
                           && (entry_q[i].tag2 == NO_VAL)
                           && !((state_q == ISS_HOLD) && (lock_q == IDX_W'(i)));
            if (!entry_q[i].busy) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    rs_select #(
        .N (RS_DEPTH)
    ) u_select (
        .ready_i (ready_vec),
        .age_i   (age_q),
        .grant_o (grant),
        .valid_o (grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign disp_ready_o = ~&busy;
    assign disp_fire    = disp_valid_i & disp_ready_o;
    assign iss_fire     = iss_valid_q & iss_ready_i;
    assign disp_tag_o   = rs_tag_t'(TAG_BASE + 32'(free_idx));
    assign fwd1         = (cdb_i.tag != NO_VAL) && (disp_tag1_i == cdb_i.tag);
    assign fwd2         = (cdb_i.tag != NO_VAL) && (disp_tag2_i == cdb_i.tag);

    always_comb begin
        age_d = age_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (entry_q[i].busy && (cdb_i.tag != NO_VAL)) begin
                if (entry_q[i].tag1 == cdb_i.tag) begin
                    entry_d[i].val1 = cdb_i.val;
                    entry_d[i].tag1 = NO_VAL;
                end
                if (entry_q[i].tag2 == cdb_i.tag) begin
                    entry_d[i].val2 = cdb_i.val;
                    entry_d[i].tag2 = NO_VAL;
                end
            end
            if (iss_fire && (lock_q == IDX_W'(i))) begin
                entry_d[i].busy = 1'b0;
            end
            // New entry is younger than every currently busy one
            if (disp_fire && (free_idx == IDX_W'(i))) begin
                entry_d[i].busy = 1'b1;
                entry_d[i].op   = disp_op_i;
                entry_d[i].val1 = fwd1 ? cdb_i.val : disp_val1_i;
                entry_d[i].tag1 = fwd1 ? NO_VAL : disp_tag1_i;
                entry_d[i].val2 = fwd2 ? cdb_i.val : disp_val2_i;
                entry_d[i].tag2 = fwd2 ? NO_VAL : disp_tag2_i;
                age_d[i]        = busy;
                for (int j = 0; j < RS_DEPTH; j++) begin
                    age_d[j][i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= '{busy: 1'b0, op: ALU_ADD, val1: '0, tag1: NO_VAL,
                                val2: '0, tag2: NO_VAL};
            end
            age_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            age_q <= age_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ISS_SELECT;
            lock_q      <= '0;
            iss_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ISS_SELECT: begin
                    if (grant_valid) begin
                        lock_q      <= grant_idx;
                        state_q     <= ISS_HOLD;
                        iss_valid_q <= 1'b1;
                    end
                end
                ISS_HOLD: begin
                    if (iss_ready_i) begin
                        if (grant_valid) begin
                            lock_q <= grant_idx;
                        end else begin
                            state_q     <= ISS_SELECT;
                            iss_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ISS_SELECT;
                    iss_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        iss_op_o   = ALU_ADD;
        iss_src1_o = '0;
        iss_src2_o = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (lock_q == IDX_W'(i)) begin
                iss_op_o   = entry_q[i].op;
                iss_src1_o = entry_q[i].val1;
                iss_src2_o = entry_q[i].val2;
            end
        end
    end

    assign iss_valid_o = iss_valid_q;
    assign iss_tag_o   = rs_tag_t'(TAG_BASE + 32'(lock_q));

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
module tb_reservation_station;
    import data_types::*;

    typedef struct packed {
        alu_op_t op;
        word32_t s1;
        word32_t s2;
        rs_tag_t tag;
    } iss_rec_t;

    logic    clk = 1'b0;
    logic    reset_ni;
    cdb_t    cdb;
    logic    disp_valid;
    logic    disp_ready;
    alu_op_t disp_op;
    word32_t disp_val1;
    word32_t disp_val2;
    rs_tag_t disp_tag1;
    rs_tag_t disp_tag2;
    rs_tag_t disp_tag;
    logic    iss_valid;
    logic    iss_ready;
    alu_op_t iss_op;
    word32_t iss_src1;
    word32_t iss_src2;
    rs_tag_t iss_tag;

    int n_checks = 0;
    int n_fail   = 0;
    iss_rec_t exp_q[$];
    iss_rec_t mon_exp;
    iss_rec_t mon_got;

    reservation_station #(
        .RS_DEPTH (4),
        .TAG_BASE (1)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .cdb_i        (cdb),
        .disp_valid_i (disp_valid),
        .disp_ready_o (disp_ready),
        .disp_op_i    (disp_op),
        .disp_val1_i  (disp_val1),
        .disp_val2_i  (disp_val2),
        .disp_tag1_i  (disp_tag1),
        .disp_tag2_i  (disp_tag2),
        .disp_tag_o   (disp_tag),
        .iss_valid_o  (iss_valid),
        .iss_ready_i  (iss_ready),
        .iss_op_o     (iss_op),
        .iss_src1_o   (iss_src1),
        .iss_src2_o   (iss_src2),
        .iss_tag_o    (iss_tag)
    );

    always #5 clk = ~clk;

    // Monitor: every accepted issue must match the next scoreboard entry
    always @(negedge clk) begin
        if (reset_ni && iss_valid && iss_ready) begin
            n_checks++;
            mon_got = '{op: iss_op, s1: iss_src1, s2: iss_src2, tag: iss_tag};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_issue got op=%0d src1=%h src2=%h tag=%0d required no issue",
                         mon_got.op, mon_got.s1, mon_got.s2, mon_got.tag);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL issue got op=%0d src1=%h src2=%h tag=%0d required op=%0d src1=%h src2=%h tag=%0d",
                             mon_got.op, mon_got.s1, mon_got.s2, mon_got.tag,
                             mon_exp.op, mon_exp.s1, mon_exp.s2, mon_exp.tag);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic dispatch(input alu_op_t op, input word32_t v1, input rs_tag_t t1,
                            input word32_t v2, input rs_tag_t t2);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_val1  = v1;
        disp_tag1  = t1;
        disp_val2  = v2;
        disp_tag2  = t2;
    endtask

    task automatic expect_issue(input alu_op_t op, input word32_t s1, input word32_t s2,
                                input rs_tag_t tag);
        exp_q.push_back('{op: op, s1: s1, s2: s2, tag: tag});
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            tick();
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        reset_ni   = 1'b0;
        cdb        = '{tag: NO_VAL, val: '0};
        disp_valid = 1'b0;
        disp_op    = ALU_ADD;
        disp_val1  = '0;
        disp_val2  = '0;
        disp_tag1  = NO_VAL;
        disp_tag2  = NO_VAL;
        iss_ready  = 1'b0;
        tick();
        tick();
        check("reset_iss_valid", 32'(iss_valid), 32'd0);
        check("reset_disp_ready", 32'(disp_ready), 32'd1);
        check("reset_disp_tag", 32'(disp_tag), 32'd1);
        reset_ni = 1'b1;
        tick();

        // Ready-at-dispatch operands issue one cycle later
        iss_ready = 1'b1;
        dispatch(ALU_ADD, 32'd5, NO_VAL, 32'd7, NO_VAL);
        expect_issue(ALU_ADD, 32'd5, 32'd7, 4'd1);
        tick();
        disp_valid = 1'b0;
        check("t1_not_yet_valid", 32'(iss_valid), 32'd0);
        tick();
        check("t1_valid", 32'(iss_valid), 32'd1);
        check("t1_tag", 32'(iss_tag), 32'd1);
        drain("t1_drain");

        // Wakeup from a later broadcast
        dispatch(ALU_SUB, 32'h99, 4'd3, 32'd2, NO_VAL);
        tick();
        disp_valid = 1'b0;
        tick();
        tick();
        check("t2_waiting", 32'(iss_valid), 32'd0);
        cdb = '{tag: 4'd3, val: 32'h10};
        expect_issue(ALU_SUB, 32'h10, 32'd2, 4'd1);
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        check("t2_one_after_bcast", 32'(iss_valid), 32'd0);
        tick();
        check("t2_valid", 32'(iss_valid), 32'd1);
        check("t2_src1", iss_src1, 32'h10);
        drain("t2_drain");

        // Same-cycle forwarding of the broadcast into the new entry
        dispatch(ALU_AND, 32'hF0, NO_VAL, 32'h55, 4'd2);
        cdb = '{tag: 4'd2, val: 32'hAB};
        expect_issue(ALU_AND, 32'hF0, 32'hAB, 4'd1);
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        disp_valid = 1'b0;
        tick();
        check("t3_valid", 32'(iss_valid), 32'd1);
        check("t3_src2", iss_src2, 32'hAB);
        drain("t3_drain");

        // Fill, stall, then drain in dispatch order with a concurrent dispatch
        iss_ready = 1'b0;
        check("t4_tag0", 32'(disp_tag), 32'd1);
        dispatch(ALU_OR, 32'd1, NO_VAL, 32'd2, NO_VAL);
        expect_issue(ALU_OR, 32'd1, 32'd2, 4'd1);
        tick();
        check("t4_tag1", 32'(disp_tag), 32'd2);
        dispatch(ALU_XOR, 32'd3, NO_VAL, 32'd4, NO_VAL);
        expect_issue(ALU_XOR, 32'd3, 32'd4, 4'd2);
        tick();
        check("t4_tag2", 32'(disp_tag), 32'd3);
        dispatch(ALU_ADD, 32'd5, NO_VAL, 32'd6, NO_VAL);
        expect_issue(ALU_ADD, 32'd5, 32'd6, 4'd3);
        tick();
        check("t4_tag3", 32'(disp_tag), 32'd4);
        dispatch(ALU_SUB, 32'd7, NO_VAL, 32'd8, NO_VAL);
        expect_issue(ALU_SUB, 32'd7, 32'd8, 4'd4);
        tick();
        check("t4_full", 32'(disp_ready), 32'd0);
        check("t4_hold_valid", 32'(iss_valid), 32'd1);
        check("t4_hold_src1", iss_src1, 32'd1);
        dispatch(ALU_AND, 32'hEE, NO_VAL, 32'hEE, NO_VAL);
        tick();
        tick();
        disp_valid = 1'b0;
        check("t4_still_full", 32'(disp_ready), 32'd0);
        check("t4_stable_src2", iss_src2, 32'd2);
        check("t4_stable_tag", 32'(iss_tag), 32'd1);
        iss_ready = 1'b1;
        tick();
        check("t4_freed", 32'(disp_ready), 32'd1);
        check("t4_free_tag", 32'(disp_tag), 32'd1);
        dispatch(ALU_ADD, 32'd9, NO_VAL, 32'd10, NO_VAL);
        expect_issue(ALU_ADD, 32'd9, 32'd10, 4'd1);
        tick();
        disp_valid = 1'b0;
        check("t4_no_bubble", 32'(iss_valid), 32'd1);
        drain("t4_drain");

        // Younger entry in a lower slot waits behind an older one on the same tag
        dispatch(ALU_ADD, 32'd1, NO_VAL, 32'd1, NO_VAL);
        expect_issue(ALU_ADD, 32'd1, 32'd1, 4'd1);
        tick();
        check("t5_tag_b", 32'(disp_tag), 32'd2);
        dispatch(ALU_XOR, 32'd0, 4'd5, 32'd3, NO_VAL);
        expect_issue(ALU_XOR, 32'h77, 32'd3, 4'd2);
        tick();
        disp_valid = 1'b0;
        tick();
        check("t5_tag_c", 32'(disp_tag), 32'd1);
        dispatch(ALU_OR, 32'd4, NO_VAL, 32'd0, 4'd5);
        expect_issue(ALU_OR, 32'd4, 32'h77, 4'd1);
        tick();
        disp_valid = 1'b0;
        cdb = '{tag: 4'd6, val: 32'hDEAD};
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        tick();
        check("t5_unmatched_cdb", 32'(iss_valid), 32'd0);
        cdb = '{tag: 4'd5, val: 32'h77};
        tick();
        cdb = '{tag: NO_VAL, val: '0};
        drain("t5_drain");

        // Asynchronous reset while an issue is held
        iss_ready = 1'b0;
        dispatch(ALU_SUB, 32'd1, NO_VAL, 32'd1, NO_VAL);
        tick();
        disp_valid = 1'b0;
        tick();
        check("t6_holding", 32'(iss_valid), 32'd1);
        #3;
        reset_ni = 1'b0;
        #1;
        check("t6_async_valid", 32'(iss_valid), 32'd0);
        check("t6_async_ready", 32'(disp_ready), 32'd1);
        check("t6_async_tag", 32'(disp_tag), 32'd1);
        tick();
        reset_ni  = 1'b1;
        iss_ready = 1'b1;
        repeat (5) tick();
        check("t6_dropped", 32'(iss_valid), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
